// File: rtl/frame_seq_pkg.sv
// Shared state encoding and default parameter values for frame_burst_sequencer.
package frame_seq_pkg;

   localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
   localparam int unsigned DEF_LENGTH_WIDTH   = 24;
   localparam int unsigned DEF_BURST_WIDTH    = 4;
   localparam int unsigned DEF_MAX_BURST      = 8;
   localparam int unsigned DEF_BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      DONE      = 3'd4
   } seq_state_t;

endpackage

// File: rtl/frame_burst_sequencer.sv
// Splits one frame write into MAX_BURST-sized bursts for a downstream burst writer.
// Optional ping-pong base selection is enabled by defining FRAME_SEQ_PINGPONG_EN.
module frame_burst_sequencer
   import frame_seq_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
   parameter int unsigned LENGTH_WIDTH   = DEF_LENGTH_WIDTH,
   parameter int unsigned BURST_WIDTH    = DEF_BURST_WIDTH,
   parameter int unsigned MAX_BURST      = DEF_MAX_BURST,
   parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_start,
   input  logic [ADDRESS_WIDTH-1:0] frame_base,
`ifdef FRAME_SEQ_PINGPONG_EN
   input  logic [ADDRESS_WIDTH-1:0] frame_base_b,
   output logic                     buf_sel,
`endif
   input  logic [LENGTH_WIDTH-1:0]  frame_words,
   output logic                     seq_busy,
   output logic                     frame_done,
   output logic                     wr_start,
   output logic [ADDRESS_WIDTH-1:0] wr_address,
   output logic [BURST_WIDTH-1:0]   wr_burstcount,
   input  logic                     wr_busy
);

   localparam logic [LENGTH_WIDTH-1:0]  MAX_LEN = LENGTH_WIDTH'(MAX_BURST);
   localparam logic [BURST_WIDTH-1:0]   MAX_BC  = BURST_WIDTH'(MAX_BURST);
   localparam logic [ADDRESS_WIDTH-1:0] BPW     = ADDRESS_WIDTH'(BYTES_PER_WORD);

   seq_state_t                state, state_next;
   logic                      start_q;       // request accepted last cycle, frame not yet launched
   logic [ADDRESS_WIDTH-1:0]  addr_q;        // address of the burst in flight (or first burst)
   logic [LENGTH_WIDTH-1:0]   remain_q;      // words not yet retired by a completed burst
   logic [LENGTH_WIDTH-1:0]   remain_after;
   logic [ADDRESS_WIDTH-1:0]  addr_after;
   logic [BURST_WIDTH-1:0]    burst_first;
   logic [BURST_WIDTH-1:0]    burst_next;
   logic [ADDRESS_WIDTH-1:0]  base_sel;
   logic                      accept;
   logic                      burst_retire;

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      accept       = (state == IDLE) && !start_q && frame_start;
      burst_retire = (state == WAIT_DONE) && !wr_busy;
      remain_after = remain_q - LENGTH_WIDTH'(wr_burstcount);
      addr_after   = addr_q + ADDRESS_WIDTH'(wr_burstcount) * BPW;
      burst_first  = (remain_q < MAX_LEN) ? remain_q[BURST_WIDTH-1:0] : MAX_BC;
      burst_next   = (remain_after < MAX_LEN) ? remain_after[BURST_WIDTH-1:0] : MAX_BC;
`ifdef FRAME_SEQ_PINGPONG_EN
      base_sel     = buf_sel ? frame_base_b : frame_base;
`else
      base_sel     = frame_base;
`endif
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (start_q) state_next = (remain_q == '0) ? DONE : ISSUE;
         ISSUE:     state_next = WAIT_ACK;
         WAIT_ACK:  if (wr_busy) state_next = WAIT_DONE;
         WAIT_DONE: if (!wr_busy) state_next = (remain_after == '0) ? DONE : ISSUE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         addr_q        <= '0;
         remain_q      <= '0;
         wr_address    <= '0;
         wr_burstcount <= '0;
`ifdef FRAME_SEQ_PINGPONG_EN
         buf_sel       <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         start_q <= accept;
         if (accept) begin
            addr_q   <= base_sel;
            remain_q <= frame_words;
         end
         if ((state == IDLE) && start_q && (remain_q != '0)) begin
            wr_address    <= addr_q;
            wr_burstcount <= burst_first;
         end
         // Retiring a burst loads the next one so it is presented with wr_start.
         if (burst_retire) begin
            addr_q   <= addr_after;
            remain_q <= remain_after;
            if (remain_after != '0) begin
               wr_address    <= addr_after;
               wr_burstcount <= burst_next;
            end
         end
`ifdef FRAME_SEQ_PINGPONG_EN
         if (state == DONE) buf_sel <= ~buf_sel;
`endif
      end
   end

   assign wr_start   = (state == ISSUE);
   assign frame_done = (state == DONE);
   assign seq_busy   = start_q || (state != IDLE);

endmodule

// File: tb/tb_frame_burst_sequencer.sv
// Directed bench for frame_burst_sequencer with a simple downstream burst-writer model.
module tb_frame_burst_sequencer;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic [31:0] frame_base;
   logic [23:0] frame_words;
   logic        seq_busy;
   logic        frame_done;
   logic        wr_start;
   logic [31:0] wr_address;
   logic [3:0]  wr_burstcount;
   logic        wr_busy;
`ifdef FRAME_SEQ_PINGPONG_EN
   logic [31:0] frame_base_b;
   logic        buf_sel;
`endif

   int n_checks;
   int n_errors;
   int cyc;
   int ack_delay;
   int busy_len;
   int done_cnt;
   int done_cyc;
   int busy_cnt;
   logic [31:0] log_addr[$];
   logic [3:0]  log_bc[$];
   int          log_cyc[$];

   frame_burst_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .frame_start   (frame_start),
      .frame_base    (frame_base),
`ifdef FRAME_SEQ_PINGPONG_EN
      .frame_base_b  (frame_base_b),
      .buf_sel       (buf_sel),
`endif
      .frame_words   (frame_words),
      .seq_busy      (seq_busy),
      .frame_done    (frame_done),
      .wr_start      (wr_start),
      .wr_address    (wr_address),
      .wr_burstcount (wr_burstcount),
      .wr_busy       (wr_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Downstream writer: logs each wr_start, raises busy ack_delay cycles later for busy_len cycles.
   initial begin
      wr_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (wr_start === 1'b1) begin
            log_addr.push_back(wr_address);
            log_bc.push_back(wr_burstcount);
            log_cyc.push_back(cyc);
            repeat (ack_delay) @(posedge clk);
            #2 wr_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #2 wr_busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] get_addr(input int i);
      if (i < log_addr.size()) return log_addr[i];
      return 'x;
   endfunction

   function automatic logic [3:0] get_bc(input int i);
      if (i < log_bc.size()) return log_bc[i];
      return 'x;
   endfunction

   function automatic int get_cyc(input int i);
      if (i < log_cyc.size()) return log_cyc[i];
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (seq_busy === 1'b1) busy_cnt++;
   endtask

   task automatic clear_mon();
      done_cnt = 0;
      done_cyc = -1;
      busy_cnt = 0;
      log_addr.delete();
      log_bc.delete();
      log_cyc.delete();
   endtask

   task automatic launch(input logic [31:0] base, input logic [23:0] words, output int c);
      frame_start = 1'b1;
      frame_base  = base;
      frame_words = words;
`ifdef FRAME_SEQ_PINGPONG_EN
      frame_base_b = base;
`endif
      c = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic check_outputs_idle(input string tag);
      n_checks++; if (wr_start !== 1'b0) begin n_errors++; $display("FAIL %s_wr_start: got %b expected 0", tag, wr_start); end
      n_checks++; if (wr_address !== 32'h0) begin n_errors++; $display("FAIL %s_wr_address: got %h expected 0", tag, wr_address); end
      n_checks++; if (wr_burstcount !== 4'h0) begin n_errors++; $display("FAIL %s_wr_burstcount: got %h expected 0", tag, wr_burstcount); end
      n_checks++; if (seq_busy !== 1'b0) begin n_errors++; $display("FAIL %s_seq_busy: got %b expected 0", tag, seq_busy); end
      n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL %s_frame_done: got %b expected 0", tag, frame_done); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      check_outputs_idle("reset");
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int c;
      logic [31:0] ea[3] = '{32'h1000, 32'h1020, 32'h1040};
      logic [3:0]  eb[3] = '{4'd8, 4'd8, 4'd4};
      int          ec[3];
      clear_mon();
      launch(32'h1000, 24'd20, c);
      ec = '{c + 2, c + 7, c + 12};
      n_checks++; if (seq_busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_early: got %b expected 1", seq_busy); end
      repeat (30) tick();
      n_checks++; if (log_addr.size() != 3) begin n_errors++; $display("FAIL basic_nbursts: got %0d expected 3", log_addr.size()); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (get_addr(i) !== ea[i]) begin n_errors++; $display("FAIL basic_addr%0d: got %h expected %h", i, get_addr(i), ea[i]); end
         n_checks++; if (get_bc(i) !== eb[i]) begin n_errors++; $display("FAIL basic_bc%0d: got %0d expected %0d", i, get_bc(i), eb[i]); end
         n_checks++; if (get_cyc(i) != ec[i]) begin n_errors++; $display("FAIL basic_cyc%0d: got %0d expected %0d", i, get_cyc(i), ec[i]); end
      end
      n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
      n_checks++; if (done_cyc != c + 17) begin n_errors++; $display("FAIL basic_done_cyc: got %0d expected %0d", done_cyc, c + 17); end
      n_checks++; if (busy_cnt != 17) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected 17", busy_cnt); end
   endtask

   task automatic test_zero_length();
      int c;
      clear_mon();
      launch(32'h7000, 24'd0, c);
      repeat (6) tick();
      n_checks++; if (log_addr.size() != 0) begin n_errors++; $display("FAIL zero_nbursts: got %0d expected 0", log_addr.size()); end
      n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
      n_checks++; if (done_cyc != c + 2) begin n_errors++; $display("FAIL zero_done_cyc: got %0d expected %0d", done_cyc, c + 2); end
      n_checks++; if (busy_cnt != 2) begin n_errors++; $display("FAIL zero_busy_cycles: got %0d expected 2", busy_cnt); end
   endtask

   task automatic test_slow_ack();
      int c;
      int unstable;
      unstable = 0;
      ack_delay = 3;
      clear_mon();
      launch(32'h2000, 24'd8, c);
      while (cyc < c + 20) begin
         tick();
         if (cyc >= c + 2 && cyc <= c + 9 && (wr_address !== 32'h2000 || wr_burstcount !== 4'd8)) unstable++;
      end
      ack_delay = 1;
      n_checks++; if (log_addr.size() != 1) begin n_errors++; $display("FAIL slow_nbursts: got %0d expected 1", log_addr.size()); end
      n_checks++; if (get_cyc(0) != c + 2) begin n_errors++; $display("FAIL slow_start_cyc: got %0d expected %0d", get_cyc(0), c + 2); end
      n_checks++; if (unstable != 0) begin n_errors++; $display("FAIL slow_hold: got %0d unstable cycles expected 0", unstable); end
      n_checks++; if (done_cyc != c + 9) begin n_errors++; $display("FAIL slow_done_cyc: got %0d expected %0d", done_cyc, c + 9); end
   endtask

   task automatic test_ignore_start();
      int c;
      logic [31:0] ea[2] = '{32'h3000, 32'h3020};
      logic [3:0]  eb[2] = '{4'd8, 4'd4};
      int          ec[2];
      clear_mon();
      launch(32'h3000, 24'd12, c);
      ec = '{c + 2, c + 7};
      while (cyc < c + 30) begin
         if (cyc == c + 1 || cyc == c + 6 || cyc == c + 12) begin
            frame_start = 1'b1;
            frame_base  = 32'hDEAD0000;
            frame_words = 24'd5;
         end
         tick();
         frame_start = 1'b0;
      end
      n_checks++; if (log_addr.size() != 2) begin n_errors++; $display("FAIL ignore_nbursts: got %0d expected 2", log_addr.size()); end
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (get_addr(i) !== ea[i]) begin n_errors++; $display("FAIL ignore_addr%0d: got %h expected %h", i, get_addr(i), ea[i]); end
         n_checks++; if (get_bc(i) !== eb[i]) begin n_errors++; $display("FAIL ignore_bc%0d: got %0d expected %0d", i, get_bc(i), eb[i]); end
         n_checks++; if (get_cyc(i) != ec[i]) begin n_errors++; $display("FAIL ignore_cyc%0d: got %0d expected %0d", i, get_cyc(i), ec[i]); end
      end
      n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL ignore_done_cnt: got %0d expected 1", done_cnt); end
      n_checks++; if (done_cyc != c + 12) begin n_errors++; $display("FAIL ignore_done_cyc: got %0d expected %0d", done_cyc, c + 12); end
   endtask

   task automatic test_wrap_back_to_back();
      int c;
      int c2;
      logic [31:0] ea[3] = '{32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0100};
      logic [3:0]  eb[3] = '{4'd8, 4'd2, 4'd1};
      int          ec[3];
      clear_mon();
      launch(32'hFFFF_FFF0, 24'd10, c);
      while (cyc < c + 13) tick();
      launch(32'h0000_0100, 24'd1, c2);
      ec = '{c + 2, c + 7, c2 + 2};
      while (cyc < c2 + 12) tick();
      n_checks++; if (log_addr.size() != 3) begin n_errors++; $display("FAIL wrap_nbursts: got %0d expected 3", log_addr.size()); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (get_addr(i) !== ea[i]) begin n_errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, get_addr(i), ea[i]); end
         n_checks++; if (get_bc(i) !== eb[i]) begin n_errors++; $display("FAIL wrap_bc%0d: got %0d expected %0d", i, get_bc(i), eb[i]); end
         n_checks++; if (get_cyc(i) != ec[i]) begin n_errors++; $display("FAIL wrap_cyc%0d: got %0d expected %0d", i, get_cyc(i), ec[i]); end
      end
      n_checks++; if (done_cnt != 2) begin n_errors++; $display("FAIL wrap_done_cnt: got %0d expected 2", done_cnt); end
      n_checks++; if (done_cyc != c2 + 7) begin n_errors++; $display("FAIL wrap_done_cyc: got %0d expected %0d", done_cyc, c2 + 7); end
   endtask

   task automatic test_reset_mid_frame();
      int c;
      int c2;
      clear_mon();
      launch(32'h4000, 24'd20, c);
      while (cyc < c + 8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_outputs_idle("midreset");
      while (cyc < c + 25) tick();
      n_checks++; if (log_addr.size() != 2) begin n_errors++; $display("FAIL midreset_nbursts: got %0d expected 2", log_addr.size()); end
      n_checks++; if (done_cnt != 0) begin n_errors++; $display("FAIL midreset_done_cnt: got %0d expected 0", done_cnt); end
      clear_mon();
      launch(32'h5000, 24'd8, c2);
      while (cyc < c2 + 12) tick();
      n_checks++; if (log_addr.size() != 1) begin n_errors++; $display("FAIL restart_nbursts: got %0d expected 1", log_addr.size()); end
      n_checks++; if (get_addr(0) !== 32'h5000) begin n_errors++; $display("FAIL restart_addr: got %h expected 5000", get_addr(0)); end
      n_checks++; if (get_bc(0) !== 4'd8) begin n_errors++; $display("FAIL restart_bc: got %0d expected 8", get_bc(0)); end
      n_checks++; if (get_cyc(0) != c2 + 2) begin n_errors++; $display("FAIL restart_cyc: got %0d expected %0d", get_cyc(0), c2 + 2); end
      n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt); end
      n_checks++; if (done_cyc != c2 + 7) begin n_errors++; $display("FAIL restart_done_cyc: got %0d expected %0d", done_cyc, c2 + 7); end
   endtask

`ifdef FRAME_SEQ_PINGPONG_EN
   task automatic test_pingpong();
      int c;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      clear_mon();
      n_checks++; if (buf_sel !== 1'b0) begin n_errors++; $display("FAIL pp_sel0: got %b expected 0", buf_sel); end
      for (int f = 0; f < 2; f++) begin
         frame_start  = 1'b1;
         frame_base   = 32'h0;
         frame_base_b = 32'h8000;
         frame_words  = 24'd8;
         c = cyc;
         tick();
         frame_start = 1'b0;
         while (cyc < c + 12) tick();
         n_checks++; if (buf_sel !== ((f == 0) ? 1'b1 : 1'b0)) begin n_errors++; $display("FAIL pp_sel_after%0d: got %b expected %b", f, buf_sel, (f == 0) ? 1'b1 : 1'b0); end
      end
      n_checks++; if (get_addr(0) !== 32'h0) begin n_errors++; $display("FAIL pp_addr0: got %h expected 0", get_addr(0)); end
      n_checks++; if (get_addr(1) !== 32'h8000) begin n_errors++; $display("FAIL pp_addr1: got %h expected 8000", get_addr(1)); end
   endtask
`endif

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      frame_base  = '0;
      frame_words = '0;
`ifdef FRAME_SEQ_PINGPONG_EN
      frame_base_b = '0;
`endif
      n_checks  = 0;
      n_errors  = 0;
      ack_delay = 1;
      busy_len  = 3;
      clear_mon();
      test_reset();
      test_basic();
      test_zero_length();
      test_slow_ack();
      test_ignore_start();
      test_wrap_back_to_back();
      test_reset_mid_frame();
`ifdef FRAME_SEQ_PINGPONG_EN
      test_pingpong();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/frame_burst_sequencer.md
FRAME_BURST_SEQUENCER -- requirements
Module: frame_burst_sequencer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: byte-address width.
REQ-002 Parameter LENGTH_WIDTH, default 24: frame length width, in words.
REQ-003 Parameter BURST_WIDTH, default 4: burst-count width.
REQ-004 Parameter MAX_BURST, default 8: largest burst issued; 1..2^BURST_WIDTH-1.
REQ-005 Parameter BYTES_PER_WORD, default 4: address increment per word.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 frame_start  in  1  one-cycle request to write one frame.
REQ-009 frame_base  in  ADDRESS_WIDTH  frame byte base address; sampled with frame_start.
REQ-010 frame_words  in  LENGTH_WIDTH  frame length in words; sampled with frame_start.
REQ-011 seq_busy  out  1  high from accepted frame_start until frame_done.
REQ-012 frame_done  out  1  one-cycle pulse when the last burst completes.
REQ-013 wr_start  out  1  one-cycle burst request to the downstream burst writer.
REQ-014 wr_address  out  ADDRESS_WIDTH  burst byte address; valid with wr_start and held until the next wr_start.
REQ-015 wr_burstcount  out  BURST_WIDTH  burst length in words; valid with wr_start and held.
REQ-016 wr_busy  in  1  downstream busy; rises at least 1 cycle after wr_start and falls when the burst finishes.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE.
REQ-018 IDLE: frame_start=1 captures base and length, sets seq_busy next cycle, and goes to ISSUE (or DONE if frame_words=0).
REQ-019 frame_start is ignored in every state other than IDLE.
REQ-020 ISSUE: wr_start=1 for exactly one cycle; wr_burstcount=min(remaining, MAX_BURST); go to WAIT_ACK.
REQ-021 WAIT_ACK: stay until wr_busy=1, then go to WAIT_DONE; there is no timeout.
REQ-022 WAIT_DONE: on wr_busy=0, remaining -= burst and address += burst*BYTES_PER_WORD; go to ISSUE if remaining>0, else DONE.
REQ-023 DONE: frame_done=1 for one cycle; seq_busy drops in the same cycle; return to IDLE.
REQ-024 Arithmetic: address wraps modulo 2^ADDRESS_WIDTH with no error; remaining is never negative.
REQ-025 frame_words=0: no wr_start; frame_done pulses 2 cycles after frame_start.
REQ-026 Latency: first wr_start is asserted 2 cycles after an accepted frame_start.
REQ-027 Next wr_start is asserted 1 cycle after wr_busy falls.
REQ-028 frame_start in the same cycle as the frame_done pulse is ignored.

Reset
REQ-029 Reset values: wr_start=0, wr_address=0, wr_burstcount=0, seq_busy=0, frame_done=0; internal counters=0; state=IDLE.
REQ-030 Reset mid-frame aborts the frame at the next edge with no frame_done and no further wr_start; downstream wr_busy is then ignored until a new frame.

Configuration
REQ-031 Macro FRAME_SEQ_PINGPONG_EN, when defined, adds input frame_base_b (ADDRESS_WIDTH) and output buf_sel (1, reset 0).
REQ-032 With FRAME_SEQ_PINGPONG_EN: each frame uses frame_base when buf_sel=0 and frame_base_b when buf_sel=1; buf_sel toggles on frame_done.
REQ-033 Without FRAME_SEQ_PINGPONG_EN: frame_base_b and buf_sel do not exist, and every frame uses frame_base.

Structure
REQ-034 Package frame_seq_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-035 The block is a single module with no sub-module; the min() and address-increment logic stay inline.

Verification
REQ-036 frame_base=0x1000, frame_words=20, MAX_BURST=8 -> bursts (0x1000,8), (0x1020,8), (0x1040,4), then one frame_done pulse.
REQ-037 frame_words=0 -> no wr_start; frame_done pulses 2 cycles after frame_start; seq_busy high for 2 cycles.
REQ-038 wr_busy rises 3 cycles after wr_start -> sequencer holds in WAIT_ACK; no duplicate wr_start; wr_address and wr_burstcount stable.
REQ-039 frame_start pulsed during a frame -> ignored; burst sequence and frame_done count unchanged.
REQ-040 reset asserted during the 2nd of 3 bursts -> all outputs at reset values next cycle; no frame_done; a new frame_start then runs normally.
REQ-041 FRAME_SEQ_PINGPONG_EN, frame_base=0x0, frame_base_b=0x8000, two 8-word frames -> bursts at 0x0 then 0x8000; buf_sel goes 0,1,0.
